// File: rtl/kb_action_mapper_pkg.sv
// Shared definitions for the keyboard action mapper: channel state encoding,
// PS/2 scan-code constants and a counter-width helper.
package kb_pkg;

    typedef enum logic [1:0] {
        ARM_WAIT = 2'd0,
        IDLE     = 2'd1,
        DEBOUNCE = 2'd2,
        HELD     = 2'd3
    } kb_state_e;

    localparam logic [7:0] KB_SPACE  = 8'h29;
    localparam logic [7:0] KB_ESC    = 8'h76;
    localparam logic [7:0] KB_ENTER  = 8'h5A;
    localparam logic [7:0] KB_1      = 8'h16;
    localparam logic [7:0] KB_RSHIFT = 8'h59;
    localparam logic [7:0] KB_NONE   = 8'h00;

    // Bits needed to hold max_count without wrapping.
    function automatic int unsigned kb_width(input int unsigned max_count);
        return $clog2(max_count) + 32'd1;
    endfunction

    function automatic int unsigned kb_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kb_action_mapper_if.sv
// Bus between the keyboard receiver / game FSM (master) and the action mapper (slave).
interface kb_action_mapper_if #(
    parameter int NUM_KEYS = 8
) ();
    logic [7:0]            kbData_i;
    logic [8*NUM_KEYS-1:0] key_codes_i;
    logic [NUM_KEYS-1:0]   enable_i;
    logic [NUM_KEYS-1:0]   toggle_clr_i;
    logic [NUM_KEYS-1:0]   press_o;
    logic [NUM_KEYS-1:0]   release_o;
    logic [NUM_KEYS-1:0]   held_o;
    logic [NUM_KEYS-1:0]   toggle_o;
    logic [NUM_KEYS-1:0]   repeat_p_o;

    modport master (
        output kbData_i, key_codes_i, enable_i, toggle_clr_i,
        input  press_o, release_o, held_o, toggle_o, repeat_p_o
    );

    modport slave (
        input  kbData_i, key_codes_i, enable_i, toggle_clr_i,
        output press_o, release_o, held_o, toggle_o, repeat_p_o
    );
endinterface

// File: rtl/kb_action_mapper_channel.sv
// One action channel: arm/debounce/held FSM with registered pulse, level and toggle outputs.
// Auto-repeat is built only when KB_AUTOREPEAT_EN is defined.
module kb_action_channel
    import kb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic Clock,
    input  logic reset,
    input  logic match_i,
    input  logic enable_i,
    input  logic toggle_clr_i,
    output logic press_o,
    output logic release_o,
    output logic held_o,
    output logic toggle_o,
    output logic repeat_p_o
);

    localparam int CW = kb_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("kb_action_channel: cycle parameters must be >= 1");
    end

    kb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            held_q, held_d;
    logic            toggle_q, toggle_d;
    logic            fire_s;

`ifdef KB_AUTOREPEAT_EN
    localparam int RW = kb_width(kb_max(REPEAT_DELAY, REPEAT_PERIOD));
    logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic            rpt_first_q, rpt_first_d;
    logic            repeat_q, repeat_d;
`endif

    // State and output registers, cleared by the synchronous reset.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q     <= ARM_WAIT;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            held_q      <= 1'b0;
            toggle_q    <= 1'b0;
`ifdef KB_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
            repeat_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            held_q      <= held_d;
            toggle_q    <= toggle_d;
`ifdef KB_AUTOREPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
            repeat_q    <= repeat_d;
`endif
        end
    end

    // Next-state logic; an enable drop outside ARM_WAIT/IDLE re-arms silently.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;
        fire_s    = 1'b0;
        case (state_q)
            ARM_WAIT: begin
                cnt_d  = '0;
                held_d = 1'b0;
                if (!match_i && enable_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ARM_WAIT;
                end
            end
            IDLE: begin
                held_d = 1'b0;
                if (match_i && enable_i) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                held_d = 1'b0;
                if (!enable_i) begin
                    state_d = ARM_WAIT;
                    cnt_d   = '0;
                end else if (!match_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    fire_s  = 1'b1;
                end else if (cnt_q < CW'(DEBOUNCE_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            HELD: begin
                if (!enable_i) begin
                    state_d = ARM_WAIT;
                    held_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!match_i) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                end else begin
                    held_d = 1'b1;
                end
            end
            default: begin
                state_d = ARM_WAIT;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase

        if (toggle_clr_i) begin
            toggle_d = 1'b0;
        end else if (fire_s) begin
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = toggle_q;
        end
    end

`ifdef KB_AUTOREPEAT_EN
    // Repeat timer: first pulse REPEAT_DELAY after press, then every REPEAT_PERIOD.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        repeat_d    = 1'b0;
        if (fire_s) begin
            rpt_cnt_d   = RW'(1);
            rpt_first_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (!rpt_first_q && rpt_cnt_q == RW'(REPEAT_DELAY)) begin
                repeat_d    = 1'b1;
                rpt_cnt_d   = RW'(1);
                rpt_first_d = 1'b1;
            end else if (rpt_first_q && rpt_cnt_q == RW'(REPEAT_PERIOD)) begin
                repeat_d  = 1'b1;
                rpt_cnt_d = RW'(1);
            end else begin
                rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
        end else begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end
    end

    assign repeat_p_o = repeat_q;
`else
    assign repeat_p_o = 1'b0;
`endif

    assign press_o   = press_q;
    assign release_o = release_q;
    assign held_o    = held_q;
    assign toggle_o  = toggle_q;

endmodule

// File: rtl/kb_action_mapper.sv
// Maps the held PS/2 scan code onto NUM_KEYS programmable action channels.
// Optional auto-repeat is enabled with the KB_AUTOREPEAT_EN macro.
module kb_action_mapper
    import kb_pkg::*;
#(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                Clock,
    input  logic                reset,
    kb_action_mapper_if.slave   bus
);

    logic [NUM_KEYS-1:0] press_s;
    logic [NUM_KEYS-1:0] release_s;
    logic [NUM_KEYS-1:0] held_s;
    logic [NUM_KEYS-1:0] toggle_s;
    logic [NUM_KEYS-1:0] repeat_s;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [7:0] code_s;
        logic       match_s;

        // A zero code disables the channel; duplicate codes all match.
        assign code_s  = bus.key_codes_i[8*i +: 8];
        assign match_s = (bus.kbData_i == code_s) && (code_s != KB_NONE);

        kb_action_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .Clock        (Clock),
            .reset        (reset),
            .match_i      (match_s),
            .enable_i     (bus.enable_i[i]),
            .toggle_clr_i (bus.toggle_clr_i[i]),
            .press_o      (press_s[i]),
            .release_o    (release_s[i]),
            .held_o       (held_s[i]),
            .toggle_o     (toggle_s[i]),
            .repeat_p_o   (repeat_s[i])
        );
    end

    assign bus.press_o    = press_s;
    assign bus.release_o  = release_s;
    assign bus.held_o     = held_s;
    assign bus.toggle_o   = toggle_s;
    assign bus.repeat_p_o = repeat_s;

endmodule
